// File: rtl/detect_count.sv
// Hit counter and run-length tracker for the detect2_5 match flag.
// Optional macro DETECT_COUNT_MAXRUN_EN enables the longest-run register.
module detect_count #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f,
    input  logic             en,
    input  logic             clr,
    output logic             evt,
    output logic [CNT_W-1:0] cnt,
    output logic [RUN_W-1:0] run,
    output logic [RUN_W-1:0] max_run,
    output logic             sat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             sat_q, sat_d;

    // Next-state and next-output logic; a hit needs f low while enabled first.
    always_comb begin
        state_d = state_q;
        evt_d   = 1'b0;
        cnt_d   = cnt_q;
        run_d   = run_q;
        sat_d   = sat_q;
        if (clr) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            run_d   = {RUN_W{1'b0}};
            sat_d   = 1'b0;
        end else if (!en) begin
            state_d = S_IDLE;
            run_d   = {RUN_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (f) begin
                        state_d = S_HIGH;
                        run_d   = RUN_ONE;
                    end else begin
                        state_d = S_LOW;
                        run_d   = {RUN_W{1'b0}};
                    end
                end
                S_LOW: begin
                    if (f) begin
                        state_d = S_HIGH;
                        evt_d   = 1'b1;
                        run_d   = RUN_ONE;
                        if (cnt_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = S_LOW;
                        run_d   = {RUN_W{1'b0}};
                    end
                end
                S_HIGH: begin
                    if (f) begin
                        state_d = S_HIGH;
                        if (run_q == RUN_MAX) begin
                            run_d = run_q;
                        end else begin
                            run_d = run_q + RUN_ONE;
                        end
                    end else begin
                        state_d = S_LOW;
                        run_d   = {RUN_W{1'b0}};
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = {RUN_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            evt_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            run_q   <= {RUN_W{1'b0}};
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            sat_q   <= sat_d;
        end
    end

`ifdef DETECT_COUNT_MAXRUN_EN
    logic [RUN_W-1:0] max_run_q, max_run_d;

    // Longest run follows the run register's next value in the same edge.
    always_comb begin
        max_run_d = max_run_q;
        if (clr) begin
            max_run_d = {RUN_W{1'b0}};
        end else if (run_d > max_run_q) begin
            max_run_d = run_d;
        end else begin
            max_run_d = max_run_q;
        end
    end

    // Longest-run register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_run_q <= {RUN_W{1'b0}};
        end else begin
            max_run_q <= max_run_d;
        end
    end

    assign max_run = max_run_q;
`else
    assign max_run = {RUN_W{1'b0}};
`endif

    assign evt = evt_q;
    assign cnt = cnt_q;
    assign run = run_q;
    assign sat = sat_q;

endmodule

// File: tb/tb_detect_count.sv
// Self-checking bench for detect_count: directed scenarios plus randomized
// traffic against an edge-detector style reference model.
module tb_detect_count;

    logic       clk = 1'b0;
    logic       rst_n, f, en, clr;
    logic       evt, sat;
    logic [7:0] cnt;
    logic [3:0] run, max_run;

    int checks = 0;
    int errors = 0;

`ifdef DETECT_COUNT_MAXRUN_EN
    localparam bit MAXRUN = 1'b1;
`else
    localparam bit MAXRUN = 1'b0;
`endif

    // Reference model: a hit is a 0->1 transition of f across two consecutive
    // enabled, un-cleared, un-reset cycles; run counts consecutive enabled highs.
    int m_cnt, m_run, m_max;
    bit m_sat, m_evt, m_prev_valid, m_prev_f;

    detect_count #(.CNT_W(8), .RUN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .f(f), .en(en), .clr(clr),
        .evt(evt), .cnt(cnt), .run(run), .max_run(max_run), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit e, input bit c, input bit ff);
        bit hit;
        rst_n = r; en = e; clr = c; f = ff;
        @(posedge clk);
        if (!r || c) begin
            m_cnt = 0; m_run = 0; m_max = 0; m_sat = 0; m_evt = 0;
            m_prev_valid = 0; m_prev_f = 0;
        end else begin
            hit   = e && ff && m_prev_valid && !m_prev_f;
            m_evt = hit;
            if (hit) begin
                if (m_cnt == 255) m_sat = 1;
                else m_cnt = m_cnt + 1;
            end
            m_run = (e && ff) ? ((m_run + 1 > 15) ? 15 : m_run + 1) : 0;
            if (MAXRUN && m_run > m_max) m_max = m_run;
            m_prev_valid = e;
            m_prev_f     = ff;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({evt, cnt, run, max_run, sat} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got evt=%0b cnt=%0d run=%0d max=%0d sat=%0b exp all 0",
                     evt, cnt, run, max_run, sat);
        end
    endtask

    task automatic test_detect25();
        int pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++) begin
            step(1'b1, 1'b1, 1'b0, (v == 2) || (v == 5));
            if (evt) pulses++;
            checks++;
            if (evt !== ((v == 2) || (v == 5))) begin
                errors++;
                $display("FAIL d25_evt v=%0d got %0b exp %0b", v, evt, (v == 2) || (v == 5));
            end
        end
        checks++;
        if (cnt !== 8'd2 || pulses != 2) begin
            errors++;
            $display("FAIL d25_cnt got cnt=%0d pulses=%0d exp 2/2", cnt, pulses);
        end
    endtask

    task automatic test_arming();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (cnt !== 8'd0 || evt !== 1'b0 || run !== 4'd2) begin
            errors++;
            $display("FAIL arm_first got cnt=%0d evt=%0b run=%0d exp 0/0/2", cnt, evt, run);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (cnt !== 8'd1 || evt !== 1'b1 || run !== 4'd1) begin
            errors++;
            $display("FAIL arm_second got cnt=%0d evt=%0b run=%0d exp 1/1/1", cnt, evt, run);
        end
    endtask

    task automatic test_run_sat();
        int exp_run;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            exp_run = (i + 1 > 15) ? 15 : i + 1;
            checks++;
            if (run !== 4'(exp_run)) begin
                errors++;
                $display("FAIL run_climb i=%0d got %0d exp %0d", i, run, exp_run);
            end
        end
        checks++;
        if (cnt !== 8'd1 || max_run !== (MAXRUN ? 4'd15 : 4'd0)) begin
            errors++;
            $display("FAIL run_final got cnt=%0d max=%0d exp 1/%0d", cnt, max_run, MAXRUN ? 15 : 0);
        end
    endtask

    task automatic test_cnt_sat();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if (evt !== 1'b1 || sat !== (i >= 255)) begin
                errors++;
                $display("FAIL sat_hit hit=%0d got evt=%0b sat=%0b exp 1/%0b", i + 1, evt, sat, i >= 255);
            end
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (cnt !== 8'd255 || sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_final got cnt=%0d sat=%0b exp 255/1", cnt, sat);
        end
    endtask

    task automatic test_clr();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (cnt !== 8'd7) begin
            errors++;
            $display("FAIL clr_pre got cnt=%0d exp 7", cnt);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({evt, cnt, run, max_run, sat} !== 18'd0) begin
            errors++;
            $display("FAIL clr_hit got evt=%0b cnt=%0d run=%0d max=%0d sat=%0b exp all 0",
                     evt, cnt, run, max_run, sat);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (evt !== 1'b0 || cnt !== 8'd0 || run !== 4'd1) begin
            errors++;
            $display("FAIL clr_idle got evt=%0b cnt=%0d run=%0d exp 0/0/1", evt, cnt, run);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (run !== 4'd5 || cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_pre got run=%0d cnt=%0d exp 5/1", run, cnt);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({evt, cnt, run, max_run, sat} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset got evt=%0b cnt=%0d run=%0d max=%0d sat=%0b exp all 0",
                     evt, cnt, run, max_run, sat);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if (evt !== 1'b0 || cnt !== 8'd0) begin
                errors++;
                $display("FAIL mid_nohit i=%0d got evt=%0b cnt=%0d exp 0/0", i, evt, cnt);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (evt !== 1'b1 || cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_rearm got evt=%0b cnt=%0d exp 1/1", evt, cnt);
        end
    endtask

    task automatic test_random();
        bit r, e, c, ff;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) >= 2);
            c  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) >= 10);
            ff = $urandom_range(0, 1) == 1;
            step(r, e, c, ff);
            checks++;
            if (evt !== m_evt || cnt !== 8'(m_cnt) || run !== 4'(m_run) ||
                max_run !== 4'(m_max) || sat !== m_sat) begin
                errors++;
                $display("FAIL rand_cyc %0d got evt=%0b cnt=%0d run=%0d max=%0d sat=%0b exp %0b/%0d/%0d/%0d/%0b",
                         i, evt, cnt, run, max_run, sat, m_evt, m_cnt, m_run, m_max, m_sat);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; f = 1'b0;
        test_reset();
        test_detect25();
        test_arming();
        test_run_sat();
        test_cnt_sat();
        test_clr();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/detect_count.md
DETECT_COUNT -- requirements
Module: detect_count

Interface
REQ-001 SHALL provide parameter: CNT_W, default 8, width of the hit counter.
REQ-002 SHALL provide parameter: RUN_W, default 4, width of the run-length and max-run registers.
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port: rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL provide port: f  input  1  match flag from the upstream detect2_5 stage; same clock domain.
REQ-006 SHALL provide port: en  input  1  count enable; when low, f is ignored.
REQ-007 SHALL provide port: clr  input  1  synchronous clear of all statistics.
REQ-008 SHALL provide port: evt  output  1  one-cycle pulse per counted hit.
REQ-009 SHALL provide port: cnt  output  CNT_W  number of counted hits (rising edges of f).
REQ-010 SHALL provide port: run  output  RUN_W  length of the current consecutive-high run of f.
REQ-011 SHALL provide port: max_run  output  RUN_W  longest run seen since reset or clear.
REQ-012 SHALL provide port: sat  output  1  sticky flag; cnt overflow was attempted.

Function
REQ-013 SHALL implement an FSM with states S_IDLE, S_LOW, S_HIGH; all outputs registered.
REQ-014 In any state, en=0 SHALL force next state S_IDLE, with cnt/max_run/sat holding, run=0, evt=0.
REQ-015 S_IDLE with en=1: f=0 -> S_LOW; f=1 -> S_HIGH without counting (arming rule: a hit requires f low while enabled first).
REQ-016 S_LOW with en=1, f=1 SHALL be a hit: -> S_HIGH, evt=1 for exactly the next cycle, cnt+1, run=1.
REQ-017 S_LOW with en=1, f=0 SHALL stay in S_LOW, with run=0.
REQ-018 S_HIGH with en=1, f=1 SHALL stay in S_HIGH, run+1 saturating at 2^RUN_W-1, evt=0.
REQ-019 S_HIGH with en=1, f=0 SHALL go to S_LOW, with run=0.
REQ-020 Latency SHALL be one cycle: f sampled high at edge k in S_LOW produces evt/cnt/run visible after edge k.
REQ-021 cnt SHALL saturate at 2^CNT_W-1; a hit at max SHALL leave cnt unchanged, still pulse evt, and set sat.
REQ-022 sat SHALL remain set until reset or clr.
REQ-023 Run entered from S_IDLE (uncounted) SHALL still count run lengths starting at 1.
REQ-024 clr SHALL have priority over en and f: next cycle state S_IDLE, cnt=0, run=0, max_run=0, sat=0, evt=0; any hit coinciding with clr SHALL be lost.

Reset
REQ-025 rst_n=0 sampled at a clk edge SHALL give state S_IDLE, evt=0, cnt=0, run=0, max_run=0, sat=0.
REQ-026 Reset mid-run SHALL discard the run; after release, counting SHALL follow the arming rule of REQ-015.
REQ-027 rst_n SHALL take priority over clr and en.

Configuration
REQ-028 When macro DETECT_COUNT_MAXRUN_EN is defined, max_run SHALL update to run's next value whenever that value exceeds the current max_run, at the same edge.
REQ-029 Without DETECT_COUNT_MAXRUN_EN, max_run SHALL be constant 0 with no register inferred; all other behaviour SHALL be unchanged.

Verification
REQ-030 Bench SHALL drive all_inputs 0..7 into detect2_5 with f fed to the block, en=1, 10 ns steps -> cnt=2 and two single-cycle evt pulses, at values 2 and 5.
REQ-031 Bench SHALL hold en=1 with f=1 already high after reset release, then f=0, then f=1 -> first high is not counted, second is (cnt=1).
REQ-032 Bench SHALL hold f=1 for 20 cycles from S_LOW -> run climbs 1..15 and holds at 15, cnt=1; max_run=15 with macro, 0 without.
REQ-033 Bench SHALL run 300 hits with CNT_W=8 -> cnt=255, sat=1 from hit 256 on, evt pulses on all 300 hits.
REQ-034 Bench SHALL assert clr coincident with a hit, cnt=7 -> next cycle cnt=0, evt=0, sat=0, state S_IDLE.
REQ-035 Bench SHALL pulse rst_n low for one cycle mid-run (run=5) -> all outputs 0 next cycle; with f still high, no hit until f returns low.
